// File: rtl/im_arbiter.sv
// Instruction-memory arbiter between a fetch port and a loader port.
// Single-cycle combinational grant, one-cycle registered response.
// The loader can lock the memory for exclusive use.
// Optional build macro IM_ARB_RR_EN: with it defined, a conflict in OPEN goes to the requester
// that did not own the last grant. Without it, the loader always wins a conflict.
module im_arbiter (
    input  logic        Clk_i,
    input  logic        Rstn_i,
    input  logic        FReq_i,
    input  logic [31:0] FAddr_i,
    output logic        FGnt_o,
    output logic        FValid_o,
    output logic [31:0] FInstr_o,
    input  logic        LReq_i,
    input  logic        LWe_i,
    input  logic [31:0] LAddr_i,
    input  logic [31:0] LWdata_i,
    input  logic        LLock_i,
    output logic        LGnt_o,
    output logic        LValid_o,
    output logic [31:0] LRdata_o,
    output logic [31:0] ImAddr_o,
    output logic        ImWe_o,
    output logic [31:0] ImWdata_o,
    input  logic [31:0] ImRdata_i
);

    typedef enum logic [0:0] {StOpen, StLocked} state_e;

    state_e      state_q, state_d;
    logic        last_owner_q, last_owner_d;  // 1: loader, 0: fetch
    logic        f_gnt, l_gnt;
    logic [29:0] gnt_word;
    logic [31:0] addr_q;
    logic        fvalid_q, lvalid_q;
    logic [31:0] finstr_q, lrdata_q;
    logic        unused_lsbs;

    // Grant decode; nothing is granted while reset is held
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (Rstn_i) begin
            if (state_q == StLocked) begin
                l_gnt = LReq_i;
            end else begin
`ifdef IM_ARB_RR_EN
                if (FReq_i && LReq_i) begin
                    f_gnt = last_owner_q;
                    l_gnt = ~last_owner_q;
                end else begin
                    f_gnt = FReq_i;
                    l_gnt = LReq_i;
                end
`else
                l_gnt = LReq_i;
                f_gnt = FReq_i & ~LReq_i;
`endif
            end
        end
    end

    // Lock FSM and last-owner tracking
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            StOpen:   if (l_gnt && LLock_i) state_d = StLocked;
            StLocked: if (!LLock_i) state_d = StOpen;
            default:  state_d = StOpen;
        endcase
        if (f_gnt) begin
            last_owner_d = 1'b0;
        end else if (l_gnt) begin
            last_owner_d = 1'b1;
        end
    end

    // Memory-side outputs; address holds its last granted value when idle
    always_comb begin
        gnt_word  = l_gnt ? LAddr_i[31:2] : FAddr_i[31:2];
        ImAddr_o  = (f_gnt || l_gnt) ? {gnt_word, 2'b00} : addr_q;
        ImWe_o    = l_gnt & LWe_i;
        ImWdata_o = ImWe_o ? LWdata_i : 32'h0;
    end

    assign unused_lsbs = ^{FAddr_i[1:0], LAddr_i[1:0]};

    assign FGnt_o   = f_gnt;
    assign LGnt_o   = l_gnt;
    // Masking by reset drops a response that was in flight when reset arrived
    assign FValid_o = fvalid_q & Rstn_i;
    assign LValid_o = lvalid_q & Rstn_i;
    assign FInstr_o = finstr_q;
    assign LRdata_o = lrdata_q;

    // State, address and response registers with synchronous reset
    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            state_q      <= StOpen;
            last_owner_q <= 1'b0;
            addr_q       <= 32'h0;
            fvalid_q     <= 1'b0;
            lvalid_q     <= 1'b0;
            finstr_q     <= 32'h0;
            lrdata_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            addr_q       <= ImAddr_o;
            fvalid_q     <= f_gnt;
            lvalid_q     <= l_gnt;
            if (f_gnt) finstr_q <= ImRdata_i;
            // A write ack leaves the read data register untouched
            if (l_gnt && !LWe_i) lrdata_q <= ImRdata_i;
        end
    end

endmodule

// File: tb/tb_im_arbiter.sv
// Scoreboard bench for im_arbiter: the stimulus pushes expected responses, a negedge monitor
// pops and compares them whenever a valid pulse appears.
module tb_im_arbiter;

    logic        Clk_i = 1'b0;
    logic        Rstn_i;
    logic        FReq_i;
    logic [31:0] FAddr_i;
    logic        FGnt_o;
    logic        FValid_o;
    logic [31:0] FInstr_o;
    logic        LReq_i;
    logic        LWe_i;
    logic [31:0] LAddr_i;
    logic [31:0] LWdata_i;
    logic        LLock_i;
    logic        LGnt_o;
    logic        LValid_o;
    logic [31:0] LRdata_o;
    logic [31:0] ImAddr_o;
    logic        ImWe_o;
    logic [31:0] ImWdata_o;
    logic [31:0] ImRdata_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] f_q[$];
    logic [31:0] l_q[$];
    logic [31:0] exp_lrdata = 32'h0;

    im_arbiter dut (
        .Clk_i     (Clk_i),
        .Rstn_i    (Rstn_i),
        .FReq_i    (FReq_i),
        .FAddr_i   (FAddr_i),
        .FGnt_o    (FGnt_o),
        .FValid_o  (FValid_o),
        .FInstr_o  (FInstr_o),
        .LReq_i    (LReq_i),
        .LWe_i     (LWe_i),
        .LAddr_i   (LAddr_i),
        .LWdata_i  (LWdata_i),
        .LLock_i   (LLock_i),
        .LGnt_o    (LGnt_o),
        .LValid_o  (LValid_o),
        .LRdata_o  (LRdata_o),
        .ImAddr_o  (ImAddr_o),
        .ImWe_o    (ImWe_o),
        .ImWdata_o (ImWdata_o),
        .ImRdata_i (ImRdata_i)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge Clk_i) begin
        if (FValid_o === 1'b1) begin
            if (f_q.size() == 0) begin
                check("f_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("f_instr", FInstr_o, f_q.pop_front());
            end
        end
        if (LValid_o === 1'b1) begin
            if (l_q.size() == 0) begin
                check("l_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("l_rdata", LRdata_o, l_q.pop_front());
            end
        end
    end

    // One cycle of stimulus with expected grant/memory-side values; pushes expected responses
    task automatic vec(input string name,
                       input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] lwd, input logic lk, input logic [31:0] rd,
                       input logic efg, input logic elg, input logic [31:0] eaddr,
                       input logic push);
        logic ewe;
        @(posedge Clk_i);
        #1;
        FReq_i = fr; FAddr_i = fa; LReq_i = lr; LWe_i = lw; LAddr_i = la;
        LWdata_i = lwd; LLock_i = lk; ImRdata_i = rd;
        #2;
        ewe = elg & lw;
        check({name, "_fgnt"}, {31'd0, FGnt_o}, {31'd0, efg});
        check({name, "_lgnt"}, {31'd0, LGnt_o}, {31'd0, elg});
        check({name, "_addr"}, ImAddr_o, eaddr);
        check({name, "_we"}, {31'd0, ImWe_o}, {31'd0, ewe});
        if (ewe) check({name, "_wdata"}, ImWdata_o, lwd);
        if (push) begin
            if (efg) f_q.push_back(rd);
            if (elg) begin
                if (!lw) exp_lrdata = rd;
                l_q.push_back(exp_lrdata);
            end
        end
    endtask

    initial begin
        Rstn_i = 1'b0; FReq_i = 1'b1; FAddr_i = 32'h3000; LReq_i = 1'b0; LWe_i = 1'b0;
        LAddr_i = 32'h0; LWdata_i = 32'h0; LLock_i = 1'b0; ImRdata_i = 32'h0;
        #3;
        check("rst_fgnt_forced", {31'd0, FGnt_o}, 32'd0);
        @(posedge Clk_i);
        @(posedge Clk_i);
        #1;
        check("rst_fvalid", {31'd0, FValid_o}, 32'd0);
        check("rst_lvalid", {31'd0, LValid_o}, 32'd0);
        check("rst_finstr", FInstr_o, 32'h0);
        check("rst_lrdata", LRdata_o, 32'h0);
        check("rst_addr", ImAddr_o, 32'h0);
        FReq_i = 1'b0;
        Rstn_i = 1'b1;

        //    name      fr    faddr        lr    lw    laddr        lwdata        lk    rdata
        //              efg   elg   eaddr        push
        vec("fetch",    1'b1, 32'h3000,    1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h20080005,
                        1'b1, 1'b0, 32'h3000,    1'b1);
        vec("lwr_pri",  1'b1, 32'h3100,    1'b1, 1'b1, 32'h3004,    32'hDEADBEEF, 1'b0, 32'h11111111,
                        1'b0, 1'b1, 32'h3004,    1'b1);
        vec("lrd_algn", 1'b0, 32'h0,       1'b1, 1'b0, 32'h3007,    32'h0,        1'b0, 32'hCAFEF00D,
                        1'b0, 1'b1, 32'h3004,    1'b1);
        vec("idle",     1'b0, 32'h3200,    1'b0, 1'b0, 32'h3300,    32'h0,        1'b0, 32'h0,
                        1'b0, 1'b0, 32'h3004,    1'b1);
        vec("f_b2b0",   1'b1, 32'h3010,    1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h00000013,
                        1'b1, 1'b0, 32'h3010,    1'b1);
        vec("f_b2b1",   1'b1, 32'h3016,    1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h00100093,
                        1'b1, 1'b0, 32'h3014,    1'b1);
        vec("conf0",    1'b1, 32'h3018,    1'b1, 1'b0, 32'h3020,    32'h0,        1'b0, 32'h55AA55AA,
                        1'b0, 1'b1, 32'h3020,    1'b1);
`ifdef IM_ARB_RR_EN
        vec("conf1",    1'b1, 32'h3028,    1'b1, 1'b0, 32'h3024,    32'h0,        1'b0, 32'h12345678,
                        1'b1, 1'b0, 32'h3028,    1'b1);
`else
        vec("conf1",    1'b1, 32'h3028,    1'b1, 1'b0, 32'h3024,    32'h0,        1'b0, 32'h12345678,
                        1'b0, 1'b1, 32'h3024,    1'b1);
`endif
        // Lock, fetch is starved while locked, loader still served
        vec("lock_wr",  1'b0, 32'h0,       1'b1, 1'b1, 32'h3030,    32'hA5A5A5A5, 1'b1, 32'h0,
                        1'b0, 1'b1, 32'h3030,    1'b1);
        for (int i = 0; i < 3; i++) begin
            vec("locked_f", 1'b1, 32'h3040, 1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 32'h77777777,
                            1'b0, 1'b0, 32'h3030, 1'b1);
        end
        vec("locked_l", 1'b1, 32'h3040,    1'b1, 1'b0, 32'h3044,    32'h0,        1'b1, 32'h0BADC0DE,
                        1'b0, 1'b1, 32'h3044,    1'b1);
        vec("unlock",   1'b1, 32'h3040,    1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h0,
                        1'b0, 1'b0, 32'h3044,    1'b1);
        vec("reopen_f", 1'b1, 32'h3040,    1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h00000073,
                        1'b1, 1'b0, 32'h3040,    1'b1);

        // Fetch granted, then reset: the response must be dropped
        vec("pre_rst",  1'b1, 32'h3050,    1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h99999999,
                        1'b1, 1'b0, 32'h3050,    1'b0);
        @(posedge Clk_i);
        #1;
        Rstn_i = 1'b0;
        #2;
        check("rst_drop_fvalid", {31'd0, FValid_o}, 32'd0);
        check("rst_fgnt_low", {31'd0, FGnt_o}, 32'd0);
        check("rst_we_low", {31'd0, ImWe_o}, 32'd0);
        exp_lrdata = 32'h0;
        // Loader asks for lock in the reset cycle; must not take effect
        LReq_i = 1'b1; LLock_i = 1'b1;
        @(posedge Clk_i);
        #1;
        Rstn_i = 1'b1;
        LReq_i = 1'b0; LLock_i = 1'b0;
        #2;
        check("post_rst_fvalid", {31'd0, FValid_o}, 32'd0);
        check("post_rst_finstr", FInstr_o, 32'h0);
        check("post_rst_fgnt_open", {31'd0, FGnt_o}, 32'd1);
        check("post_rst_addr", ImAddr_o, 32'h3050);

        // Continuous conflict from reset
        Rstn_i = 1'b0;
        @(posedge Clk_i);
        #1;
        Rstn_i = 1'b1;
        FReq_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef IM_ARB_RR_EN
            if (i % 2 == 0) begin
                vec("rr_l", 1'b1, 32'h3100, 1'b1, 1'b0, 32'h3200, 32'h0, 1'b0, 32'h40 + i,
                            1'b0, 1'b1, 32'h3200, 1'b1);
            end else begin
                vec("rr_f", 1'b1, 32'h3100, 1'b1, 1'b0, 32'h3200, 32'h0, 1'b0, 32'h40 + i,
                            1'b1, 1'b0, 32'h3100, 1'b1);
            end
`else
            vec("fix_l", 1'b1, 32'h3100, 1'b1, 1'b0, 32'h3200, 32'h0, 1'b0, 32'h40 + i,
                         1'b0, 1'b1, 32'h3200, 1'b1);
`endif
        end
        vec("drain",    1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h0,
                        1'b0, 1'b0, 32'h3200 - (32'h100 * 32'(`ifdef IM_ARB_RR_EN 1 `else 0 `endif)),
                        1'b1);
        repeat (3) @(posedge Clk_i);
        #1;
        check("f_queue_empty", f_q.size(), 32'd0);
        check("l_queue_empty", l_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
